// File: rtl/cpu_bus_responder.sv
// Byte-wide memory-bus responder: synchronous RAM, UART TX queue, RX holding byte,
// stop flag, and an optional cycle counter enabled by defining CPU_BUS_CYCLE_CNT_EN.
module cpu_bus_responder #(
   parameter int ADDR_WIDTH = 17,
   parameter int TX_DEPTH   = 16
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        program_done,
   output logic        tx_overflow
);

   localparam int PW = $clog2(TX_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] C_DEPTH     = CW'(TX_DEPTH);
   localparam logic [CW-1:0] C_FULL_MARK = CW'(TX_DEPTH - 2);
   localparam logic [17:0]   A_TX        = 18'h30000;
   localparam logic [17:0]   A_STOP      = 18'h30004;

   typedef enum logic [1:0] {SRC_HOLE, SRC_RAM, SRC_IO} src_t;

   logic [17:0]           w_addr;
   logic                  w_unused_addr;
   logic                  w_is_io;
   logic                  w_is_ram;
   logic                  w_rd;
   logic [ADDR_WIDTH-1:0] w_ram_idx;
   logic [7:0]            w_io_rdata;

   logic [7:0]            r_ram [0:(1<<ADDR_WIDTH)-1];
   logic [7:0]            r_ram_q;
   logic [7:0]            r_io_q;
   src_t                  r_rd_src;

   logic [7:0]            r_rx_data;
   logic                  r_rx_valid;
   logic                  w_rx_rd;

   logic [7:0]            r_tx_mem [0:TX_DEPTH-1];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic [CW-1:0]         w_count_nxt;
   logic                  w_pop;
   logic                  w_wr_tx;
   logic                  w_wr_stop;
   logic                  w_push_req;
   logic                  w_push_ok;
   logic [7:0]            w_push_data;

   assign w_addr        = mem_a[17:0];
   assign w_unused_addr = ^mem_a[31:18];
   assign w_is_io       = (w_addr[17:16] == 2'b11);
   assign w_is_ram      = !w_is_io && ((w_addr >> ADDR_WIDTH) == 18'd0);
   assign w_rd          = !mem_wr;
   assign w_ram_idx     = mem_a[ADDR_WIDTH-1:0];

   // RAM has no reset so it survives a mid-run reset.
   always_ff @(posedge clk_in) begin
      if (mem_wr && w_is_ram) begin
         r_ram[w_ram_idx] <= mem_dout;
      end
      if (w_rd && w_is_ram) begin
         r_ram_q <= r_ram[w_ram_idx];
      end
   end

`ifdef CPU_BUS_CYCLE_CNT_EN
   logic [31:0] r_cnt;
   logic [31:0] r_snap;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_cnt  <= 32'd0;
         r_snap <= 32'd0;
      end else begin
         r_cnt <= r_cnt + 32'd1;
         if (w_rd && (w_addr == A_STOP)) begin
            r_snap <= r_cnt;
         end
      end
   end
`endif

   always_comb begin
      w_io_rdata = 8'h00;
      if (w_addr == A_TX) begin
         w_io_rdata = r_rx_valid ? r_rx_data : 8'h00;
      end
`ifdef CPU_BUS_CYCLE_CNT_EN
      // Byte 0 comes live from the counter; bytes 1-3 from the snapshot it latches.
      else if (w_addr[17:2] == A_STOP[17:2]) begin
         case (w_addr[1:0])
            2'd0:    w_io_rdata = r_cnt[7:0];
            2'd1:    w_io_rdata = r_snap[15:8];
            2'd2:    w_io_rdata = r_snap[23:16];
            default: w_io_rdata = r_snap[31:24];
         endcase
      end
`endif
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_rd_src <= SRC_HOLE;
         r_io_q   <= 8'h00;
      end else if (w_rd) begin
         if (w_is_ram) begin
            r_rd_src <= SRC_RAM;
         end else if (w_is_io) begin
            r_rd_src <= SRC_IO;
            r_io_q   <= w_io_rdata;
         end else begin
            r_rd_src <= SRC_HOLE;
         end
      end
   end

   always_comb begin
      mem_din = 8'h00;
      case (r_rd_src)
         SRC_RAM: mem_din = r_ram_q;
         SRC_IO:  mem_din = r_io_q;
         default: mem_din = 8'h00;
      endcase
   end

   assign w_rx_rd = w_rd && (w_addr == A_TX);

   // A same-cycle strobe wins over the read-clear so the new byte stays pending.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_rx_data  <= 8'h00;
         r_rx_valid <= 1'b0;
      end else if (rx_valid) begin
         r_rx_data  <= rx_data;
         r_rx_valid <= 1'b1;
      end else if (w_rx_rd) begin
         r_rx_valid <= 1'b0;
      end
   end

   assign tx_valid    = (r_count != '0);
   assign tx_data     = tx_valid ? r_tx_mem[r_rd_ptr] : 8'h00;
   assign w_pop       = tx_valid && tx_ready;
   assign w_wr_tx     = mem_wr && (w_addr == A_TX) && (mem_dout != 8'h00);
   assign w_wr_stop   = mem_wr && (w_addr == A_STOP);
   assign w_push_req  = w_wr_tx || w_wr_stop;
   assign w_push_data = w_wr_stop ? 8'h00 : mem_dout;
   assign w_push_ok   = w_push_req && ((r_count < C_DEPTH) || w_pop);
   assign w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop);

   always_ff @(posedge clk_in) begin
      if (w_push_ok) begin
         r_tx_mem[r_wr_ptr] <= w_push_data;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         io_buffer_full <= 1'b0;
         program_done   <= 1'b0;
         tx_overflow    <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count <= w_count_nxt;
         // Two-entry margin absorbs the CPU's one-cycle reaction lag.
         io_buffer_full <= (w_count_nxt >= C_FULL_MARK);
         if (w_wr_stop) begin
            program_done <= 1'b1;
         end
         if (w_push_req && !w_push_ok) begin
            tx_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder with a queue/array reference model checked every cycle.
module tb_cpu_bus_responder;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        program_done;
   logic        tx_overflow;

   int n_checks = 0;
   int n_errors = 0;

   cpu_bus_responder dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .mem_a(mem_a), .mem_dout(mem_dout),
      .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .program_done(program_done),
      .tx_overflow(tx_overflow)
   );

   always #5 clk_in = ~clk_in;

   // Reference model state
   logic [7:0]  m_ram [int];
   logic [7:0]  m_txq [$];
   logic [7:0]  m_din;
   bit          m_din_known;
   bit          m_full, m_done, m_ovf, m_rx_v;
   logic [7:0]  m_rx_d;
   logic [31:0] m_cnt, m_snap;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_txq.delete();
      m_din = 8'h00; m_din_known = 1'b1;
      m_full = 0; m_done = 0; m_ovf = 0; m_rx_v = 0; m_rx_d = 8'h00;
      m_cnt = 32'd0; m_snap = 32'd0;
   endtask

   task automatic model_step();
      logic [17:0] a;
      bit          pop, io, accept, known;
      logic [7:0]  rd, pdata;
      a = mem_a[17:0];
      io = (a[17:16] == 2'b11);
      pop = (m_txq.size() > 0) && tx_ready;
      accept = 0; pdata = 8'h00;
      if (!mem_wr) begin
         rd = 8'h00; known = 1;
         if (io) begin
            if (a == 18'h30000) begin
               if (m_rx_v) rd = m_rx_d;
               m_rx_v = 0;
            end
`ifdef CPU_BUS_CYCLE_CNT_EN
            else if (a >= 18'h30004 && a <= 18'h30007) begin
               if (a == 18'h30004) begin
                  m_snap = m_cnt;
                  rd = m_cnt[7:0];
               end else begin
                  rd = 8'(m_snap >> (8 * (int'(a) - 32'h30004)));
               end
            end
`endif
         end else if (a < 18'h20000) begin
            if (m_ram.exists(int'(a))) rd = m_ram[int'(a)];
            else known = 0;
         end
         m_din = rd; m_din_known = known;
      end else begin
         if (!io && a < 18'h20000) m_ram[int'(a)] = mem_dout;
         if (io && ((a == 18'h30000 && mem_dout != 8'h00) || a == 18'h30004)) begin
            pdata = (a == 18'h30004) ? 8'h00 : mem_dout;
            if (a == 18'h30004) m_done = 1;
            if (m_txq.size() < 16 || pop) accept = 1;
            else m_ovf = 1;
         end
      end
      if (pop) void'(m_txq.pop_front());
      if (accept) m_txq.push_back(pdata);
      if (rx_valid) begin
         m_rx_v = 1; m_rx_d = rx_data;
      end
      m_full = (m_txq.size() >= 14);
      m_cnt = m_cnt + 32'd1;
   endtask

   always @(negedge rst_n_in) model_reset();
   always @(posedge clk_in) if (rst_n_in) model_step();

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk_in) begin
      if (rst_n_in) begin
         if (m_din_known) check("mem_din", 32'(mem_din), 32'(m_din));
         check("tx_valid", 32'(tx_valid), 32'(m_txq.size() > 0));
         check("tx_data", 32'(tx_data), (m_txq.size() > 0) ? 32'(m_txq[0]) : 32'd0);
         check("io_buffer_full", 32'(io_buffer_full), 32'(m_full));
         check("program_done", 32'(program_done), 32'(m_done));
         check("tx_overflow", 32'(tx_overflow), 32'(m_ovf));
      end
   end

   task automatic cyc(input logic [31:0] a, input logic w, input logic [7:0] d);
      mem_a = a; mem_wr = w; mem_dout = d;
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(32'h20000, 1'b0, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic [7:0]  b [4];
      mem_a = 32'h20000; mem_wr = 0; mem_dout = 0;
      tx_ready = 0; rx_data = 0; rx_valid = 0; rst_n_in = 0;
      model_reset();
      repeat (3) @(posedge clk_in);
      #1;
      check("rst_mem_din", 32'(mem_din), 32'h0);
      check("rst_tx_valid", 32'(tx_valid), 32'h0);
      check("rst_tx_data", 32'(tx_data), 32'h0);
      check("rst_full", 32'(io_buffer_full), 32'h0);
      check("rst_done", 32'(program_done), 32'h0);
      check("rst_ovf", 32'(tx_overflow), 32'h0);
      #2 rst_n_in = 1;

      // RAM
      cyc(32'h00010, 1, 8'hA5); cyc(32'h00010, 0, 8'h00);
      check("lit_ram_a5", 32'(mem_din), 32'hA5);
      cyc(32'h1FFFF, 1, 8'h3C); cyc(32'h1FFFF, 0, 8'h00);
      check("lit_ram_top", 32'(mem_din), 32'h3C);
      cyc(32'h20000, 1, 8'hEE); cyc(32'h20000, 0, 8'h00);
      check("lit_hole", 32'(mem_din), 32'h00);
      cyc(32'hFFFC0010, 0, 8'h00);
      check("lit_upper_bits_ignored", 32'(mem_din), 32'hA5);
      cyc(32'h00050, 1, 8'h11);
      check("lit_write_holds_din", 32'(mem_din), 32'hA5);
      cyc(32'h00123, 1, 8'hC7);

      // TX basic
      tx_ready = 1;
      cyc(32'h30000, 1, 8'h48);
      check("lit_tx_h", 32'(tx_data), 32'h48);
      cyc(32'h30000, 1, 8'h69);
      check("lit_tx_i", 32'(tx_data), 32'h69);
      cyc(32'h30000, 1, 8'h00);
      check("lit_tx_zero_ignored", 32'(tx_valid), 32'h0);
      cyc(32'h30004, 1, 8'h55);
      check("lit_stop_valid", 32'(tx_valid), 32'h1);
      check("lit_stop_byte", 32'(tx_data), 32'h00);
      check("lit_done", 32'(program_done), 32'h1);
      idle(1);

      // Back-pressure, overflow, push-with-pop at full, in-order drain
      tx_ready = 0;
      for (int i = 0; i < 17; i++) begin
         cyc(32'h30000, 1, 8'(8'h10 + i));
         if (i == 12) check("lit_full_after13", 32'(io_buffer_full), 32'h0);
         if (i == 13) check("lit_full_after14", 32'(io_buffer_full), 32'h1);
         if (i == 15) check("lit_ovf_after16", 32'(tx_overflow), 32'h0);
      end
      check("lit_ovf_after17", 32'(tx_overflow), 32'h1);
      tx_ready = 1;
      cyc(32'h30000, 1, 8'h99);
      for (int k = 0; k < 16; k++) begin
         check("lit_drain", 32'(tx_data), (k < 15) ? 32'(8'h11 + k) : 32'h99);
         idle(1);
      end
      check("lit_drained", 32'(tx_valid), 32'h0);
      check("lit_full_clear", 32'(io_buffer_full), 32'h0);
      tx_ready = 0;

      // RX
      rx_data = 8'h5A; rx_valid = 1; idle(1); rx_valid = 0;
      cyc(32'h30000, 0, 8'h00);
      check("lit_rx_5a", 32'(mem_din), 32'h5A);
      cyc(32'h30000, 0, 8'h00);
      check("lit_rx_empty", 32'(mem_din), 32'h00);
      rx_data = 8'h77; rx_valid = 1;
      cyc(32'h30000, 0, 8'h00);
      rx_valid = 0;
      check("lit_rx_same_cycle", 32'(mem_din), 32'h00);
      cyc(32'h30000, 0, 8'h00);
      check("lit_rx_77", 32'(mem_din), 32'h77);

      // Counter snapshot
      while (m_cnt < 32'd1000) idle(1);
      for (int k = 0; k < 4; k++) begin
         cyc(32'h30004 + k, 0, 8'h00);
         b[k] = mem_din;
      end
      v = {b[3], b[2], b[1], b[0]};
`ifdef CPU_BUS_CYCLE_CNT_EN
      check("lit_cnt_snapshot", v, 32'd1000);
`else
      check("lit_cnt_absent", v, 32'd0);
`endif

      // Async reset with queued bytes
      for (int k = 1; k <= 5; k++) cyc(32'h30000, 1, 8'(k));
      check("lit_queued", 32'(tx_valid), 32'h1);
      #2 rst_n_in = 0;
      #1;
      check("lit_async_tx_valid", 32'(tx_valid), 32'h0);
      check("lit_async_tx_data", 32'(tx_data), 32'h0);
      check("lit_async_done", 32'(program_done), 32'h0);
      repeat (2) @(posedge clk_in);
      #3 rst_n_in = 1;
      cyc(32'h00123, 0, 8'h00);
      check("lit_ram_kept", 32'(mem_din), 32'hC7);
      check("lit_queue_empty", 32'(tx_valid), 32'h0);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cpu_bus_responder.md
# cpu_bus_responder

Responder end of the CPU's byte-wide memory bus (`mem_a`/`mem_dout`/`mem_wr` in, `mem_din`/`io_buffer_full` out). It decodes every cycle's bus request into a synchronous byte RAM or the I/O space at `mem_a[17:16]==2'b11`. The I/O space provides a UART TX byte queue, a single-byte RX holding register, a cycle counter and a program-stop flag. It replaces the behavioural RAM/HCI models in simulation and sits directly beside `cpu` at top level.

## Interface
- `ADDR_WIDTH`, 17, RAM byte-address width (RAM size = 2^ADDR_WIDTH bytes)
- `TX_DEPTH`, 16, TX queue entries (power of two, ≥4)
- `clk_in`  input  1  system clock
- `rst_n_in`  input  1  asynchronous, active-low reset
- `mem_a`  input  32  byte address from CPU (only [17:0] decoded)
- `mem_dout`  input  8  write data from CPU
- `mem_wr`  input  1  1 = write, 0 = read (a read is performed every non-write cycle)
- `mem_din`  output  8  read data to CPU, registered
- `io_buffer_full`  output  1  TX queue near full, registered
- `tx_data`  output  8  head of TX queue
- `tx_valid`  output  1  TX queue non-empty
- `tx_ready`  input  1  UART accepts `tx_data` when `tx_valid && tx_ready`
- `rx_data`  input  8  received UART byte
- `rx_valid`  input  1  one-cycle strobe loading `rx_data`
- `program_done`  output  1  sticky, set by stop write
- `tx_overflow`  output  1  sticky, TX push dropped

## Operation
- Decode: IO when `mem_a[17:16]==2'b11`; RAM when not IO and `mem_a[17:ADDR_WIDTH]==0`; otherwise a hole (reads return 0x00, writes dropped).
- RAM write: `ram[mem_a[ADDR_WIDTH-1:0]] <= mem_dout`. RAM read: synchronous. RAM contents are not reset.
- IO write 0x30000: push `mem_dout` to the TX queue. A value of 0x00 is ignored.
- IO write 0x30004: set `program_done` and push 0x00 to the TX queue. This is the only way 0x00 enters the queue.
- Other IO writes: ignored.
- IO read 0x30000: return the RX holding byte and clear its valid flag. If the holding register is empty, return 0x00.
- IO read 0x30004–0x30007: return byte `mem_a[1:0]` of the cycle-count snapshot, little-endian. A read of 0x30004 returns `cnt[7:0]` and simultaneously latches the snapshot from `cnt`, so bytes 5–7 come from the same 32-bit value.
- Other IO reads: 0x00.
- Cycle counter `cnt`: 32-bit, +1 every clock after reset release, wraps 0xFFFFFFFF→0.
- RX holding register: `rx_valid` loads `rx_data` and sets valid. If `rx_valid` and a 0x30000 read occur in the same cycle, the read returns the old contents (0x00 if empty) and the new byte stays valid.
- TX queue: circular FIFO with a count of 0..TX_DEPTH.
  - Pop when `tx_valid && tx_ready`.
  - A push is accepted if count < TX_DEPTH, or if count == TX_DEPTH with a pop in the same cycle.
  - Otherwise the push is dropped and `tx_overflow` is set.
  - Simultaneous accepted push and pop: count unchanged, pointers both advance and wrap modulo TX_DEPTH.
- `io_buffer_full` is registered: 1 when next count ≥ TX_DEPTH−2. The 2-entry margin covers the CPU's one-cycle reaction lag.

## Timing
- Read latency 1: address presented in cycle N → `mem_din` valid after edge N+1 and held until the next read edge. Write cycles leave `mem_din` unchanged.
- Writes take effect at the edge ending the write cycle. A read of the same address in the next cycle returns the new value (no bypass needed).
- TX push is visible on `tx_valid` one cycle after the write cycle.
- Async reset forces: `mem_din`=0, `io_buffer_full`=0, `tx_valid`=0, `tx_data`=0, `program_done`=0, `tx_overflow`=0, `cnt`=0, snapshot=0, RX valid=0, queue pointers/count=0.
- Reset mid-transfer discards queued TX bytes and any pending RX byte. RAM is untouched.

## Configuration
- `CPU_BUS_CYCLE_CNT_EN` defined: cycle counter and snapshot are implemented as above.
- Not defined: no counter or snapshot registers; reads of 0x30004–0x30007 return 0x00. All other behaviour is identical.

## Test plan
- RAM: write 0xA5 @0x00010, then read @0x00010 the next cycle → `mem_din`=0xA5 one cycle later. Read @0x1FFFF after writing 0x3C → 0x3C. Read @0x20000 → 0x00.
- TX: writes 'H','i',0x00 to 0x30000 with `tx_ready`=1 → `tx_data` shows 0x48 then 0x69; nothing for 0x00. Write to 0x30004 → 0x00 emitted and `program_done`=1.
- Back-pressure: hold `tx_ready`=0 and write 16 non-zero bytes → `io_buffer_full` rises after the 14th push. The 17th push is dropped and `tx_overflow`=1. Release `tx_ready` → 16 bytes drain in order.
- RX: `rx_valid` with 0x5A, then read 0x30000 → 0x5A. Second read → 0x00. Same-cycle strobe of 0x77 and read → returns 0x00, next read returns 0x77.
- Counter (macro on): after 1000 cycles from reset release, reads 0x30004..0x30007 → a consistent snapshot of 999/1000 ± read offset, bytes little-endian. With macro off → all 0x00.
- Async reset asserted while 5 bytes are queued → `tx_valid` drops without waiting for a clock edge. After release the queue is empty and a RAM location written before reset still reads back its value.
